line_arbiter: RTL
=================

# line_arbiter

Fixed-priority arbiter that shares the single cacheline adaptor between the instruction cache and the data cache. It accepts whole-line read requests from the icache and line read/write requests from the dcache, serializes them onto the adaptor's line port, and routes the response and read line back to the owning cache. It sits between the two `cache` instances and `cacheline_adaptor` in `mp4`.

## Interface
- `s_offset`, default 5: line offset bits; line width `size = (2**s_offset)*8` (256 bits at default).
- `STARVE_MAX`, default 4: consecutive dcache grants tolerated while the icache waits (used only with `LINE_ARB_FAIR_EN`).

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_pmem_read` in 1: icache line read request, level, held until `i_pmem_resp`.
- `i_pmem_address` in 32: icache line address.
- `i_pmem_rdata` out size: line returned to icache.
- `i_pmem_resp` out 1: icache completion pulse.
- `d_pmem_read` in 1: dcache line read request.
- `d_pmem_write` in 1: dcache line write-back request.
- `d_pmem_address` in 32: dcache line address.
- `d_pmem_wdata` in size: dcache write-back line.
- `d_pmem_rdata` out size: line returned to dcache.
- `d_pmem_resp` out 1: dcache completion pulse.
- `pmem_read_c` out 1: read to cacheline adaptor.
- `pmem_write_c` out 1: write to cacheline adaptor.
- `pmem_address_c` out 32: address to adaptor.
- `pmem_wdata_c` out size: write line to adaptor.
- `pmem_rdata_c` in size: line from adaptor.
- `pmem_resp_c` in 1: adaptor completion, one-cycle pulse.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: sample requests. Dcache request (`d_pmem_read | d_pmem_write`) wins over icache. Grant latches address, wdata, and op into registers. The FSM goes to D_BUSY or I_BUSY. With no request, it stays in IDLE.
- `d_pmem_read` and `d_pmem_write` both high is illegal. Write takes precedence.
- I_BUSY/D_BUSY: drive the registered op, address, and wdata to the adaptor. Hold them constant regardless of changes on the cache inputs. On `pmem_resp_c`, capture `pmem_rdata_c` into the owner's rdata register, record the owner, and go to RESP.
- RESP: assert the owner's `*_pmem_resp` for exactly one cycle. All `pmem_*_c` controls are low. Return to IDLE.
- Only the owner's resp ever pulses. The other cache's resp stays 0.
- `i_pmem_rdata` and `d_pmem_rdata` are registers. They hold their last captured line until the next capture for that cache.
- Writes also pass through RESP. The dcache rdata register is not updated on a write.

## Timing
- Reset values: all `*_resp`, `pmem_read_c`, `pmem_write_c` = 0; `pmem_address_c`, `pmem_wdata_c`, both rdata outputs = 0. FSM = IDLE, starvation counter = 0.
- Grant latency: request seen in IDLE at cycle 0 → `pmem_read_c`/`pmem_write_c` high from cycle 1.
- Completion: `pmem_resp_c` at cycle k → owner resp and valid rdata at cycle k+1.
- Back-to-back: next grant is made in IDLE at cycle k+2. The earliest next adaptor request is at cycle k+3.
- Control to the adaptor is low in IDLE and RESP. This guarantees at least one low cycle between transactions.
- A request deasserted mid-transaction is ignored. The transaction completes and resp still pulses.
- `rst` mid-transaction forces IDLE next cycle and drops adaptor controls. No resp is issued. The adaptor is reset by the same `rst`.
- `pmem_resp_c` arriving in IDLE or RESP is ignored.

## Configuration
- `LINE_ARB_FAIR_EN` defined:
  - A saturating counter (width `$clog2(STARVE_MAX+1)`) increments on each dcache grant made while `i_pmem_read` is high.
  - It clears on every icache grant.
  - When the counter equals `STARVE_MAX` and both caches are requesting, the icache wins.
- `LINE_ARB_FAIR_EN` undefined:
  - Strict dcache priority, no counter.
  - The icache can starve indefinitely under continuous dcache traffic.

## Test plan
- Single icache read: `i_pmem_read`=1, address 0x0000_1000, adaptor resp at cycle 6 with line 0xA5…A5 → `pmem_read_c`=1 at cycles 1–6; `i_pmem_resp`=1 at cycle 7 only; `i_pmem_rdata`=0xA5…A5; `d_pmem_resp` stays 0.
- Simultaneous requests: icache read 0x100 and dcache read 0x200 at cycle 0 → first `pmem_address_c`=0x200. After `d_pmem_resp`, `pmem_address_c`=0x100 is granted with at least one idle cycle between.
- Dcache write-back: `d_pmem_write`=1, wdata 0x1234…, address 0x8000_0040 → `pmem_write_c`=1 with matching address and wdata; `d_pmem_resp` pulses once; `d_pmem_rdata` is unchanged.
- Reset mid-transaction: `rst` in cycle 3 of an icache read → cycle 4 has all outputs at reset values. A later `pmem_resp_c` produces no `i_pmem_resp`.
- Starvation, `LINE_ARB_FAIR_EN` defined, `STARVE_MAX`=4: icache held high with continuous dcache reads → exactly 4 dcache grants, then the icache is granted. Without the macro, the icache is never granted while the dcache keeps requesting.

Source files
------------

// File: rtl/line_arbiter.sv
// Fixed-priority arbiter sharing one cacheline adaptor between icache and dcache.
// Optional macro LINE_ARB_FAIR_EN adds a starvation counter that lets the icache through.
module line_arbiter #(
   parameter int  s_offset   = 5,
   parameter int  STARVE_MAX = 4,
   localparam int size       = (2**s_offset)*8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_pmem_read,
   input  logic [31:0]     i_pmem_address,
   output logic [size-1:0] i_pmem_rdata,
   output logic            i_pmem_resp,
   input  logic            d_pmem_read,
   input  logic            d_pmem_write,
   input  logic [31:0]     d_pmem_address,
   input  logic [size-1:0] d_pmem_wdata,
   output logic [size-1:0] d_pmem_rdata,
   output logic            d_pmem_resp,
   output logic            pmem_read_c,
   output logic            pmem_write_c,
   output logic [31:0]     pmem_address_c,
   output logic [size-1:0] pmem_wdata_c,
   input  logic [size-1:0] pmem_rdata_c,
   input  logic            pmem_resp_c
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [31:0]       addr_q, addr_d;
   logic [size-1:0]   wdata_q, wdata_d;
   logic [size-1:0]   i_rdata_q, i_rdata_d;
   logic [size-1:0]   d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;
   logic              d_req;
   logic              i_win;

   assign d_req = d_pmem_read | d_pmem_write;

`ifdef LINE_ARB_FAIR_EN
   localparam int CW = $clog2(STARVE_MAX+1);
   logic [CW-1:0] cnt_q, cnt_d;

   // icache overrides dcache priority once it has waited through STARVE_MAX dcache grants
   assign i_win = i_pmem_read & (~d_req | (cnt_q == CW'(STARVE_MAX)));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         if (i_win) begin
            cnt_d = {CW{1'b0}};
         end else if (d_req && i_pmem_read && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign i_win = i_pmem_read & ~d_req;
`endif

   always_comb begin
      state_d   = state_q;
      read_d    = read_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_resp_d  = 1'b0;
      d_resp_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_win) begin
               state_d = I_BUSY;
               read_d  = 1'b1;
               write_d = 1'b0;
               addr_d  = i_pmem_address;
            end else if (d_req) begin
               // a read+write collision is treated as a write
               state_d = D_BUSY;
               read_d  = ~d_pmem_write;
               write_d = d_pmem_write;
               addr_d  = d_pmem_address;
               wdata_d = d_pmem_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         I_BUSY: begin
            if (pmem_resp_c) begin
               i_rdata_d = pmem_rdata_c;
               i_resp_d  = 1'b1;
               read_d    = 1'b0;
               write_d   = 1'b0;
               state_d   = RESP;
            end else begin
               state_d = I_BUSY;
            end
         end
         D_BUSY: begin
            if (pmem_resp_c) begin
               if (!write_q) begin
                  d_rdata_d = pmem_rdata_c;
               end else begin
                  d_rdata_d = d_rdata_q;
               end
               d_resp_d = 1'b1;
               read_d   = 1'b0;
               write_d  = 1'b0;
               state_d  = RESP;
            end else begin
               state_d = D_BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= {size{1'b0}};
         i_rdata_q <= {size{1'b0}};
         d_rdata_q <= {size{1'b0}};
         i_resp_q  <= 1'b0;
         d_resp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_resp_q  <= i_resp_d;
         d_resp_q  <= d_resp_d;
      end
   end

   assign pmem_read_c    = read_q;
   assign pmem_write_c   = write_q;
   assign pmem_address_c = addr_q;
   assign pmem_wdata_c   = wdata_q;
   assign i_pmem_rdata   = i_rdata_q;
   assign d_pmem_rdata   = d_rdata_q;
   assign i_pmem_resp    = i_resp_q;
   assign d_pmem_resp    = d_resp_q;

endmodule
